bcd_sub16_seq: RTL and testbench

- Digit-serial packed-BCD subtractor. It computes diff = a - b - bin over 4 BCD digits, one digit per cycle, least significant digit first.
- It is the inverse-direction companion to the combinational 16-bit BCD adder (a + b + cin). It sits in the same register-to-register datapath.
- Operands are taken through a valid/ready handshake. The result is held with valid/ready backpressure until the consumer takes it.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_sub.sv | 25 ++
 rtl/bcd_sub16_seq.sv | 120 ++++++++++++
 tb/tb_bcd_sub16_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, FSM state type and digit helper
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_RADIX   = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // True when a nibble is a legal decimal digit (0..9)
    function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] v);
        return v < BCD_DIGIT_W'(BCD_RADIX);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// rtl/bcd_digit_sub.sv - combinational single BCD digit subtract with borrow
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       brw_in,
    output logic [3:0] d,
    output logic       brw_out,
    output logic       bad
);

    logic [5:0] t;
    logic [5:0] t_adj;

    // Six-bit two's-complement difference; a negative result borrows ten from the next digit
    always_comb begin
        t       = {2'b00, x} - {2'b00, y} - {5'b00000, brw_in};
        t_adj   = t + 6'(BCD_RADIX);
        brw_out = t[5];
        d       = brw_out ? t_adj[3:0] : t[3:0];
        bad     = !is_bcd_digit(x) || !is_bcd_digit(y);
    end

endmodule

// File: rtl/bcd_sub16_seq.sv
// rtl/bcd_sub16_seq.sv - digit-serial packed-BCD subtractor with valid/ready handshakes
module bcd_sub16_seq
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*NDIG-1:0]     a,
    input  logic [4*NDIG-1:0]     b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*NDIG-1:0]     diff,
    output logic                  bout,
    output logic                  err
);

    localparam int W  = BCD_DIGIT_W * NDIG;
    localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   k_d;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    diff_q;
    logic            brw_q;
    logic            bout_q;
    logic            err_q;
    logic            out_valid_q;
    logic            in_ready_q;

    logic [3:0]      x_dig;
    logic [3:0]      y_dig;
    logic [3:0]      d_dig;
    logic            brw_d;
    logic            bad_dig;
    logic            err_d;
    logic            last_dig;

    // Select the current digit pair and form next counter / sticky error values
    always_comb begin
        x_dig    = a_q[BCD_DIGIT_W*k_q +: BCD_DIGIT_W];
        y_dig    = b_q[BCD_DIGIT_W*k_q +: BCD_DIGIT_W];
        k_d      = k_q + KW'(1);
        last_dig = (k_q == KW'(NDIG - 1));
        // First digit restarts the flag so err reflects only the current operation
        err_d    = bad_dig | ((k_q == '0) ? 1'b0 : err_q);
    end

    bcd_digit_sub u_digit (
        .x       (x_dig),
        .y       (y_dig),
        .brw_in  (brw_q),
        .d       (d_dig),
        .brw_out (brw_d),
        .bad     (bad_dig)
    );

    // Control FSM: accept operands, walk digits LSD first, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            brw_q       <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        brw_q      <= bin;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    diff_q[BCD_DIGIT_W*k_q +: BCD_DIGIT_W] <= d_dig;
                    brw_q <= brw_d;
                    err_q <= err_d;
                    k_q   <= k_d;
                    if (last_dig) begin
                        bout_q      <= brw_d;
                        out_valid_q <= 1'b1;
                        k_q         <= '0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_sub16_seq.sv
// tb/tb_bcd_sub16_seq.sv - self-checking bench for bcd_sub16_seq
module tb_bcd_sub16_seq;

    localparam int NDIG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_sub16_seq #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .err       (err)
    );

    // Decimal reference: interpret operands as numbers, subtract, wrap by 10^NDIG
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                                  output logic [15:0] md, output logic mbo);
        int va, vb, v;
        va = 0;
        vb = 0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            va = va * 10 + int'((ma >> (4 * i)) & 16'hF);
            vb = vb * 10 + int'((mb >> (4 * i)) & 16'hF);
        end
        v   = va - vb - int'(mbin);
        mbo = (v < 0);
        if (v < 0) v = v + 10000;
        md = '0;
        for (int i = 0; i < NDIG; i++) begin
            md = md | 16'((v % 10) << (4 * i));
            v  = v / 10;
        end
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) r = r | 16'($urandom_range(0, 9) << (4 * i));
        return r;
    endfunction

    // Drive one operation; returns the result seen when out_valid first rises
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin, input bit pulse,
                         output logic [15:0] rd, output logic rbo, output logic rerr,
                         output int lat, output bit tmo);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        a = ta;
        b = tb;
        bin = tbin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        bin = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin
            if (pulse) in_valid = lat[0];
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        tmo  = !out_valid;
        rd   = diff;
        rbo  = bout;
        rerr = err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        bin = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (diff !== 16'h0) begin bad++; $display("FAIL reset_diff: got %h want 0000", diff); end
        total++; if (bout !== 1'b0) begin bad++; $display("FAIL reset_bout: got %b want 0", bout); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] ta [4] = '{16'h0042, 16'h0000, 16'h1000, 16'h9999};
        logic [15:0] tb [4] = '{16'h0017, 16'h0001, 16'h0001, 16'h9999};
        logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] ed [4] = '{16'h0025, 16'h9999, 16'h0998, 16'h9999};
        logic        eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] rd;
        logic rbo, rerr;
        int lat;
        bit tmo;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], tc[i], 1'b0, rd, rbo, rerr, lat, tmo);
            total++; if (tmo) begin bad++; $display("FAIL basic_timeout[%0d]: got no out_valid want out_valid", i); end
            total++; if (lat !== NDIG + 1) begin bad++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, NDIG + 1); end
            total++; if (rd !== ed[i]) begin bad++; $display("FAIL basic_diff[%0d]: got %h want %h", i, rd, ed[i]); end
            total++; if (rbo !== eb[i]) begin bad++; $display("FAIL basic_bout[%0d]: got %b want %b", i, rbo, eb[i]); end
            total++; if (rerr !== 1'b0) begin bad++; $display("FAIL basic_err[%0d]: got %b want 0", i, rerr); end
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle[%0d]: got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] rd;
        logic rbo, rerr;
        int lat;
        bit tmo;
        out_ready = 1'b0;
        do_op(16'h5555, 16'h1111, 1'b0, 1'b1, rd, rbo, rerr, lat, tmo);
        total++; if (tmo) begin bad++; $display("FAIL bp_timeout: got no out_valid want out_valid"); end
        total++; if (rd !== 16'h4444) begin bad++; $display("FAIL bp_diff: got %h want 4444", rd); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'h9999;
            b = 16'h0000;
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
            total++; if (diff !== 16'h4444) begin bad++; $display("FAIL bp_hold_diff[%0d]: got %h want 4444", i, diff); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_ready: got %b want 1", in_ready); end
        total++; if (diff !== 16'h4444) begin bad++; $display("FAIL bp_diff_kept: got %h want 4444", diff); end
    endtask

    task automatic test_err();
        logic [15:0] ta [4] = '{16'h00A0, 16'h0010, 16'h000C, 16'h0000};
        logic [15:0] tb [4] = '{16'h0000, 16'h0000, 16'h0000, 16'hF000};
        logic [15:0] ed [4] = '{16'h00A0, 16'h0010, 16'h000C, 16'hB000};
        logic        eb [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic        ee [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] rd;
        logic rbo, rerr;
        int lat;
        bit tmo;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], 1'b0, 1'b0, rd, rbo, rerr, lat, tmo);
            total++; if (tmo) begin bad++; $display("FAIL err_timeout[%0d]: got no out_valid want out_valid", i); end
            total++; if (rerr !== ee[i]) begin bad++; $display("FAIL err_flag[%0d]: got %b want %b", i, rerr, ee[i]); end
            total++; if (rd !== ed[i]) begin bad++; $display("FAIL err_diff[%0d]: got %h want %h", i, rd, ed[i]); end
            total++; if (rbo !== eb[i]) begin bad++; $display("FAIL err_bout[%0d]: got %b want %b", i, rbo, eb[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        logic rbo, rerr;
        int lat;
        bit tmo;
        int seen;
        out_ready = 1'b1;
        @(negedge clk);
        a = 16'h0042;
        b = 16'h0017;
        bin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        total++; if (diff !== 16'h0) begin bad++; $display("FAIL rstmid_diff: got %h want 0000", diff); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_result: got %0d pulses want 0", seen); end
        do_op(16'h0042, 16'h0017, 1'b0, 1'b0, rd, rbo, rerr, lat, tmo);
        total++; if (tmo) begin bad++; $display("FAIL rstmid_fresh_timeout: got no out_valid want out_valid"); end
        total++; if (rd !== 16'h0025) begin bad++; $display("FAIL rstmid_fresh_diff: got %h want 0025", rd); end
        total++; if (lat !== NDIG + 1) begin bad++; $display("FAIL rstmid_fresh_lat: got %0d want %0d", lat, NDIG + 1); end
    endtask

    task automatic test_back_to_back();
        int prev;
        int hits;
        @(negedge clk);
        out_ready = 1'b1;
        a = 16'h0042;
        b = 16'h0017;
        bin = 1'b0;
        in_valid = 1'b1;
        prev = -1;
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                hits++;
                total++; if (diff !== 16'h0025) begin bad++; $display("FAIL b2b_diff[%0d]: got %h want 0025", i, diff); end
                if (prev >= 0) begin
                    total++; if (i - prev !== NDIG + 2) begin bad++; $display("FAIL b2b_period: got %0d want %0d", i - prev, NDIG + 2); end
                end
                prev = i;
            end
        end
        in_valid = 1'b0;
        total++; if (hits !== 5) begin bad++; $display("FAIL b2b_count: got %0d want 5", hits); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] ra, rb, rd, ed;
        logic rc, rbo, rerr, eb;
        int lat;
        bit tmo;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            rc = 1'($urandom);
            model(ra, rb, rc, ed, eb);
            do_op(ra, rb, rc, i[0], rd, rbo, rerr, lat, tmo);
            total++; if (tmo || rd !== ed) begin bad++; $display("FAIL rand_diff[%0d] %h-%h-%b: got %h want %h", i, ra, rb, rc, rd, ed); end
            total++; if (rbo !== eb) begin bad++; $display("FAIL rand_bout[%0d]: got %b want %b", i, rbo, eb); end
            total++; if (rerr !== 1'b0) begin bad++; $display("FAIL rand_err[%0d]: got %b want 0", i, rerr); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_err();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
